// File: rtl/e_exec_pkg.sv
// Shared encodings for the P6 execute stage: ALU/MDU opcodes and MDU FSM states.
package e_exec_pkg;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_OR   = 4'd2;
    localparam logic [3:0] ALUOP_LUI  = 4'd3;
    localparam logic [3:0] ALUOP_AND  = 4'd4;
    localparam logic [3:0] ALUOP_SLT  = 4'd5;
    localparam logic [3:0] ALUOP_SLTU = 4'd6;
    localparam logic [3:0] ALUOP_XOR  = 4'd7;
    localparam logic [3:0] ALUOP_NOR  = 4'd8;
    localparam logic [3:0] ALUOP_SLL  = 4'd9;
    localparam logic [3:0] ALUOP_SRL  = 4'd10;
    localparam logic [3:0] ALUOP_SRA  = 4'd11;

    localparam logic [2:0] MDOP_NONE  = 3'd0;
    localparam logic [2:0] MDOP_MULT  = 3'd1;
    localparam logic [2:0] MDOP_MULTU = 3'd2;
    localparam logic [2:0] MDOP_DIV   = 3'd3;
    localparam logic [2:0] MDOP_DIVU  = 3'd4;
    localparam logic [2:0] MDOP_MTHI  = 3'd5;
    localparam logic [2:0] MDOP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_e;

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers. The result is computed
// at start, held, and committed to HI/LO when the latency counter expires.
module e_mdu
    import e_exec_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ari1_e,
    input  logic [WIDTH-1:0] ari2_e,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy,
    output logic             md_stall
);

    localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             res_ok_q, res_ok_d;

    logic             is_signed_mul;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic             div_ovf;
    logic [WIDTH-1:0] q_s, r_s, q_u, r_u, quot, rem;

    assign is_signed_mul = (md_op == MDOP_MULT);
    assign a_ext = is_signed_mul ? {{WIDTH{ari1_e[WIDTH-1]}}, ari1_e} : {{WIDTH{1'b0}}, ari1_e};
    assign b_ext = is_signed_mul ? {{WIDTH{ari2_e[WIDTH-1]}}, ari2_e} : {{WIDTH{1'b0}}, ari2_e};
    // Low 2*WIDTH bits of the extended product are exact for both signednesses.
    assign prod  = a_ext * b_ext;

    assign div_ovf = (ari1_e == MIN_INT) && (ari2_e == {WIDTH{1'b1}});
    assign q_s = div_ovf ? MIN_INT : $unsigned($signed(ari1_e) / $signed(ari2_e));
    assign r_s = div_ovf ? '0 : $unsigned($signed(ari1_e) % $signed(ari2_e));
    assign q_u = ari1_e / ari2_e;
    assign r_u = ari1_e % ari2_e;
    assign quot = (md_op == MDOP_DIV) ? q_s : q_u;
    assign rem  = (md_op == MDOP_DIV) ? r_s : r_u;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_ok_d = res_ok_q;
        unique case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    case (md_op)
                        MDOP_MULT, MDOP_MULTU: begin
                            state_d  = ST_MUL;
                            cnt_d    = MUL_CNT;
                            res_hi_d = prod[2*WIDTH-1:WIDTH];
                            res_lo_d = prod[WIDTH-1:0];
                            res_ok_d = 1'b1;
                        end
                        MDOP_DIV, MDOP_DIVU: begin
                            state_d  = ST_DIV;
                            cnt_d    = DIV_CNT;
                            res_hi_d = rem;
                            res_lo_d = quot;
                            // Divide by zero still runs the full latency but never commits.
                            res_ok_d = (ari2_e != '0);
                        end
                        MDOP_MTHI: hi_d = ari1_e;
                        MDOP_MTLO: lo_d = ari1_e;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    if (res_ok_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            res_ok_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_ok_q <= res_ok_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign md_busy  = (state_q != ST_IDLE);
    assign md_stall = md_busy | (md_start & (md_op >= MDOP_MULT) & (md_op <= MDOP_DIVU));

endmodule

// File: rtl/e_exec_unit.sv
// P6 execute stage: combinational ALU plus the multi-cycle MDU.
// Define E_EXEC_SHIFT_EN to build the sll/srl/sra shifter (aluop 9-11).
module e_exec_unit
    import e_exec_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 5,
    parameter int unsigned DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ari1_e,
    input  logic [WIDTH-1:0] ari2_e,
    input  logic [3:0]       aluop,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic [WIDTH-1:0] aluout_e,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             md_busy,
    output logic             md_stall
);

`ifdef E_EXEC_SHIFT_EN
    localparam int unsigned SH_W = $clog2(WIDTH);
    logic [SH_W-1:0] shamt;
    assign shamt = ari1_e[SH_W-1:0];
`endif

    always_comb begin
        aluout_e = '0;
        case (aluop)
            ALUOP_ADD:  aluout_e = ari1_e + ari2_e;
            ALUOP_SUB:  aluout_e = ari1_e - ari2_e;
            ALUOP_OR:   aluout_e = ari1_e | ari2_e;
            ALUOP_LUI:  aluout_e = ari2_e << (WIDTH / 2);
            ALUOP_AND:  aluout_e = ari1_e & ari2_e;
            ALUOP_SLT:  aluout_e = {{(WIDTH-1){1'b0}}, ($signed(ari1_e) < $signed(ari2_e))};
            ALUOP_SLTU: aluout_e = {{(WIDTH-1){1'b0}}, (ari1_e < ari2_e)};
            ALUOP_XOR:  aluout_e = ari1_e ^ ari2_e;
            ALUOP_NOR:  aluout_e = ~(ari1_e | ari2_e);
`ifdef E_EXEC_SHIFT_EN
            ALUOP_SLL:  aluout_e = ari2_e << shamt;
            ALUOP_SRL:  aluout_e = ari2_e >> shamt;
            ALUOP_SRA:  aluout_e = $unsigned($signed(ari2_e) >>> shamt);
`endif
            default:    aluout_e = '0;
        endcase
    end

    e_mdu #(
        .WIDTH   (WIDTH),
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .ari1_e   (ari1_e),
        .ari2_e   (ari2_e),
        .md_op    (md_op),
        .md_start (md_start),
        .hi       (hi),
        .lo       (lo),
        .md_busy  (md_busy),
        .md_stall (md_stall)
    );

endmodule
